// File: rtl/proj_base_feeder.sv
// ASCII nucleotide -> 2-bit base feeder with per-read framing; latency 2 edges accept->base_valid.
// Backpressure: s_ready low while full or draining; stall freezes pops only, pushes continue until full.
`timescale 1ns/1ps
module proj_base_feeder #(
    parameter int BASE_LEN   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          s_char,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    input  logic                stall,
    output logic [BASE_LEN-1:0] base_data,
    output logic                base_valid,
    output logic                base_last,
    output logic                read_done,
    output logic [LEN_W-1:0]    read_len,
    output logic [7:0]          err_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
    typedef logic [BASE_LEN:0] entry_t;

    function automatic entry_t decode(input logic [7:0] c);
        entry_t r;
        r = '0;
        case (c)
            8'h41, 8'h61: r = {1'b1, BASE_LEN'(0)};
            8'h43, 8'h63: r = {1'b1, BASE_LEN'(1)};
            8'h47, 8'h67: r = {1'b1, BASE_LEN'(2)};
            8'h54, 8'h74: r = {1'b1, BASE_LEN'(3)};
            default:      r = '0;
        endcase
        return r;
    endfunction

    state_t                state_q;
    entry_t                mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [BASE_LEN-1:0]   base_data_q;
    logic                  base_valid_q, base_last_q, read_done_q;
    logic [LEN_W-1:0]      read_len_q, len_cnt_q;
    logic [7:0]            err_cnt_q;

    entry_t                dec;
    logic                  chr_ok, accept, push, pop, ready_c;

    always_comb begin
        dec      = decode(s_char);
        chr_ok   = dec[BASE_LEN];
        ready_c  = (state_q != DRAIN) && (count_q < DEPTH_C);
        accept   = s_valid && ready_c;
        push     = accept && chr_ok;
        // A push into an empty FIFO is only visible from the next edge: no bypass.
        pop      = (count_q != '0) && !stall;
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_last, dec[BASE_LEN-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            base_data_q  <= '0;
            base_valid_q <= 1'b0;
            base_last_q  <= 1'b0;
            read_done_q  <= 1'b0;
            read_len_q   <= '0;
            len_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            base_valid_q <= pop;
            base_last_q  <= pop && mem_q[rd_ptr_q][BASE_LEN];
            read_done_q  <= 1'b0;
            if (pop) begin
                base_data_q <= mem_q[rd_ptr_q][BASE_LEN-1:0];
            end
            if (pop && (len_cnt_q != {LEN_W{1'b1}})) begin
                len_cnt_q <= len_cnt_q + 1'b1;
            end
            if (accept && !chr_ok && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= s_last ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (accept && s_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Empty FIFO here also means no pop can be happening on this edge.
                    if (count_q == '0) begin
                        state_q     <= IDLE;
                        read_done_q <= 1'b1;
                        read_len_q  <= len_cnt_q;
                        len_cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready    = ready_c;
    assign base_data  = base_data_q;
    assign base_valid = base_valid_q;
    assign base_last  = base_last_q;
    assign read_done  = read_done_q;
    assign read_len   = read_len_q;
    assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_proj_base_feeder.sv
// Bench for proj_base_feeder: character-level reference model feeds a scoreboard checked by a monitor.
`timescale 1ns/1ps
module tb_proj_base_feeder;
    localparam int BL = 2;
    localparam int FD = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_char = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          stall = 1'b0;
    logic          s_ready;
    logic [BL-1:0] base_data;
    logic          base_valid, base_last, read_done;
    logic [LW-1:0] read_len;
    logic [7:0]    err_cnt;

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    logic [2:0] exp_base_q[$];
    int         exp_len_q[$];
    int         bv_cyc_q[$];
    int         exp_err = 0;
    int         rd_bases = 0;
    bit         rand_stall = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    proj_base_feeder #(.BASE_LEN(BL), .FIFO_DEPTH(FD), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .s_char(s_char), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .stall(stall), .base_data(base_data), .base_valid(base_valid),
        .base_last(base_last), .read_done(read_done), .read_len(read_len), .err_cnt(err_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: position in "ACGT" is the code; lower case folds to upper.
    function automatic logic [2:0] ref_enc(input logic [7:0] c);
        string s;
        logic [7:0] u;
        s = "ACGT";
        u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
        for (int i = 0; i < 4; i++) begin
            if (s[i] == u) return {1'b1, 2'(i)};
        end
        return 3'b000;
    endfunction

    task automatic model_accept(input logic [7:0] c, input logic last);
        logic [2:0] r;
        r = ref_enc(c);
        if (r[2]) begin
            exp_base_q.push_back({last, r[1:0]});
            rd_bases++;
        end else if (exp_err < 255) begin
            exp_err++;
        end
        if (last) begin
            exp_len_q.push_back(rd_bases);
            rd_bases = 0;
        end
    endtask

    task automatic send(input logic [7:0] c, input logic last, output int acc);
        int t;
        t = 0;
        acc = -1;
        @(negedge clk);
        if (rand_stall) stall = ($urandom_range(0, 3) == 0);
        s_char = c; s_valid = 1'b1; s_last = last;
        while (!s_ready && t < 300) begin
            @(negedge clk);
            if (rand_stall) stall = ($urandom_range(0, 3) == 0);
            t++;
        end
        if (!s_ready) begin
            chk("send_timeout", int'(s_ready), 1);
            s_valid = 1'b0;
        end else begin
            acc = cyc + 1;
            model_accept(c, last);
            @(posedge clk);
        end
    endtask

    task automatic send_str(input string s, output int first_acc);
        int a;
        first_acc = -1;
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], (i == s.len() - 1), a);
            if (i == 0) first_acc = a;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; stall = 1'b0;
        while ((exp_base_q.size() != 0 || exp_len_q.size() != 0 || !s_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("drain_timeout", exp_base_q.size() + exp_len_q.size(), 0);
    endtask

    task automatic monitor();
        logic [2:0] e;
        int last_cyc;
        bit have_last;
        last_cyc = 0;
        have_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_last = 1'b0;
            end else begin
                if (base_valid) begin
                    bv_cyc_q.push_back(cyc);
                    if (exp_base_q.size() == 0) begin
                        chk("base_unexpected", int'(base_valid), 0);
                    end else begin
                        e = exp_base_q.pop_front();
                        chk("base_data", int'(base_data), int'(e[1:0]));
                        chk("base_last", int'(base_last), int'(e[2]));
                        if (base_last) begin
                            last_cyc = cyc;
                            have_last = 1'b1;
                        end
                    end
                end else begin
                    chk("base_last_without_valid", int'(base_last), 0);
                end
                if (read_done) begin
                    if (exp_len_q.size() == 0) begin
                        chk("read_done_unexpected", int'(read_done), 0);
                    end else begin
                        chk("read_len", int'(read_len), exp_len_q.pop_front());
                        chk("done_bases_left", exp_base_q.size(), 0);
                        if (have_last) chk("done_timing", cyc, last_cyc + 1);
                    end
                    have_last = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, n0, acc;
        string st, tbl;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_base_valid", int'(base_valid), 0);
        chk("rst_base_data", int'(base_data), 0);
        chk("rst_base_last", int'(base_last), 0);
        chk("rst_read_done", int'(read_done), 0);
        chk("rst_read_len", int'(read_len), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        #2 rst_n = 1'b1;

        // ACGT: four bases back to back, first one edge after acceptance
        n0 = bv_cyc_q.size();
        send_str("ACGT", a);
        wait_idle();
        if (bv_cyc_q.size() >= n0 + 4) begin
            chk("acgt_latency", bv_cyc_q[n0] - a, 1);
            chk("acgt_consecutive", bv_cyc_q[n0 + 3] - bv_cyc_q[n0], 3);
        end else begin
            chk("acgt_base_count", bv_cyc_q.size() - n0, 4);
        end
        chk("base_data_hold", int'(base_data), 3);
        chk("acgt_err_cnt", int'(err_cnt), exp_err);

        send_str("AXnG", a);
        wait_idle();
        chk("axng_err_cnt", int'(err_cnt), 2);

        // Single last character goes straight to DRAIN
        send(8'h74, 1'b1, a);
        @(negedge clk);
        s_valid = 1'b0;
        chk("t_s_ready_drain", int'(s_ready), 0);
        chk("t_no_base_yet", int'(base_valid), 0);
        @(negedge clk);
        chk("t_base_valid", int'(base_valid), 1);
        chk("t_base_data", int'(base_data), 3);
        chk("t_base_last", int'(base_last), 1);
        chk("t_s_ready_still_drain", int'(s_ready), 0);
        wait_idle();
        chk("t_s_ready_idle", int'(s_ready), 1);

        send_str("GAN", a);
        wait_idle();
        chk("invalid_last_err_cnt", int'(err_cnt), 3);

        // Stall while presenting 10 characters: only FD are taken
        st = "ACGTTGCAGA";
        n0 = bv_cyc_q.size();
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            stall = 1'b1;
            s_char = st[acc]; s_valid = 1'b1; s_last = (acc == 9);
            if (s_ready) begin
                model_accept(s_char, s_last);
                acc++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        chk("stall_accepted", acc, FD);
        chk("stall_s_ready", int'(s_ready), 0);
        chk("stall_no_base", bv_cyc_q.size() - n0, 0);
        stall = 1'b0;
        for (int i = acc; i < 10; i++) send(st[i], (i == 9), a);
        wait_idle();
        chk("stall_bases_out", bv_cyc_q.size() - n0, 10);

        // Reset with 5 bases buffered mid-read
        send(8'h54, 1'b0, a);
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        send_str("ACGTA", a);
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_base_data", int'(base_data), 0);
        chk("mid_rst_base_valid", int'(base_valid), 0);
        chk("mid_rst_read_len", int'(read_len), 0);
        chk("mid_rst_err_cnt", int'(err_cnt), 0);
        chk("mid_rst_s_ready", int'(s_ready), 1);
        exp_base_q.delete();
        exp_len_q.delete();
        rd_bases = 0;
        exp_err = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        stall = 1'b0;
        n0 = bv_cyc_q.size();
        repeat (10) @(negedge clk);
        chk("post_rst_no_base", bv_cyc_q.size() - n0, 0);
        chk("post_rst_s_ready", int'(s_ready), 1);

        // Randomised reads with random stall and gaps
        tbl = "ACGTacgtXNn-";
        rand_stall = 1'b1;
        for (int r = 0; r < 40; r++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                send(tbl[$urandom_range(0, 11)], (i == len - 1), a);
                if ($urandom_range(0, 4) == 0) begin
                    @(negedge clk);
                    s_valid = 1'b0;
                end
            end
        end
        rand_stall = 1'b0;
        wait_idle();
        chk("random_err_cnt", int'(err_cnt), exp_err);

        // Error counter saturation
        for (int i = 0; i < 260; i++) send(8'h58, (i == 259), a);
        wait_idle();
        chk("err_cnt_saturated", int'(err_cnt), 255);

        chk("scoreboard_leftover", exp_base_q.size() + exp_len_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
